// File: rtl/pixel_occupancy_map_if.sv
// Pixel-write snoop bus plus occupancy query/response port for pixel_occupancy_map.
// master = drawing/game side, slave = occupancy map.
interface pixel_occupancy_map_if;
    logic       writeEn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       clear_req;
    logic       query_valid;
    logic [7:0] query_x;
    logic [6:0] query_y;
    logic       query_ready;
    logic       hit_valid;
    logic       hit;
    logic       clearing;
    logic [7:0] oob_count;

    modport master (
        output writeEn, x, y, colour, clear_req, query_valid, query_x, query_y,
        input  query_ready, hit_valid, hit, clearing, oob_count
    );

    modport slave (
        input  writeEn, x, y, colour, clear_req, query_valid, query_x, query_y,
        output query_ready, hit_valid, hit, clearing, oob_count
    );
endinterface

// File: rtl/pixel_occupancy_map.sv
// One-bit occupancy shadow of the VGA frame, fed by snooped pixel writes, with a one-cycle query port.
// Optional macro PIXEL_OOB_COUNT_EN builds the saturating out-of-range write counter.
module pixel_occupancy_map #(
    parameter int         WIDTH     = 160,
    parameter int         HEIGHT    = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic clk,
    input  logic reset,
    pixel_occupancy_map_if.slave bus
);
    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [8:0]  WIDTH_L   = 9'(WIDTH);
    localparam logic [7:0]  HEIGHT_L  = 8'(HEIGHT);
    localparam logic [14:0] STRIDE    = 15'(WIDTH);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;

    logic        hit_valid_q;
    logic        oob_q;
    logic        fwd_q;
    logic        fwd_bit_q;
    logic        ram_rd_q;

    logic        mem [DEPTH];

    logic        run;
    logic        wr_in_range, q_in_range;
    logic [14:0] wr_addr, q_addr;
    logic        pix_we, pix_bit, q_acc;
    logic        ram_we, ram_wdata;
    logic [14:0] ram_waddr;

    assign run         = (state_q == S_RUN);
    assign wr_in_range = ({1'b0, bus.x} < WIDTH_L) && ({1'b0, bus.y} < HEIGHT_L);
    assign q_in_range  = ({1'b0, bus.query_x} < WIDTH_L) && ({1'b0, bus.query_y} < HEIGHT_L);
    assign wr_addr     = {8'd0, bus.y} * STRIDE + {7'd0, bus.x};
    assign q_addr      = {8'd0, bus.query_y} * STRIDE + {7'd0, bus.query_x};
    assign pix_bit     = (bus.colour != BG_COLOUR);
    assign pix_we      = run && bus.writeEn && wr_in_range;
    assign q_acc       = run && bus.query_valid;

    // The single write port is shared: the clear sweep owns it outside S_RUN.
    assign ram_we    = pix_we || !run;
    assign ram_waddr = run ? wr_addr : clr_addr_q;
    assign ram_wdata = run && pix_bit;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (q_acc && q_in_range) begin
            ram_rd_q <= mem[q_addr];
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (bus.clear_req) begin
            state_d    = S_CLEAR;
            clr_addr_d = 15'd0;
        end else if (!run) begin
            if (clr_addr_q == LAST_ADDR) begin
                state_d    = S_RUN;
                clr_addr_d = 15'd0;
            end else begin
                clr_addr_d = clr_addr_q + 15'd1;
            end
        end
    end

    // fwd_q resets high with fwd_bit_q low so hit reads 0 before any RAM read has happened.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= 15'd0;
            hit_valid_q <= 1'b0;
            oob_q       <= 1'b0;
            fwd_q       <= 1'b1;
            fwd_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            hit_valid_q <= q_acc;
            if (q_acc) begin
                oob_q     <= !q_in_range;
                fwd_q     <= pix_we && (wr_addr == q_addr);
                fwd_bit_q <= pix_bit;
            end
        end
    end

`ifdef PIXEL_OOB_COUNT_EN
    logic [7:0] oob_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob_cnt_q <= 8'd0;
        end else if (bus.clear_req) begin
            oob_cnt_q <= 8'd0;
        end else if (run && bus.writeEn && !wr_in_range && (oob_cnt_q != 8'hFF)) begin
            oob_cnt_q <= oob_cnt_q + 8'd1;
        end
    end

    assign bus.oob_count = oob_cnt_q;
`else
    assign bus.oob_count = 8'd0;
`endif

    assign bus.query_ready = run;
    assign bus.clearing    = !run;
    assign bus.hit_valid   = hit_valid_q;
    assign bus.hit         = oob_q || (fwd_q ? fwd_bit_q : ram_rd_q);
endmodule

// File: tb/tb_pixel_occupancy_map.sv
// Directed bench for pixel_occupancy_map: scoreboard queue of expected hits checked against each response.
module tb_pixel_occupancy_map;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pixel_occupancy_map_if bus();

    pixel_occupancy_map #(
        .WIDTH(160),
        .HEIGHT(120),
        .BG_COLOUR(3'b000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    bit   model [0:19199];
    bit   exp_q [$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   n;
    bit   resp_seen;
    bit   e;
    logic [7:0] oob_exp;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: optional write and/or query, then check the response produced by it.
    task automatic cycle(input string tag, input bit we, input int wx, input int wy,
                         input logic [2:0] col, input bit qv, input int qx, input int qy);
        bus.writeEn     = we;
        bus.x           = 8'(wx);
        bus.y           = 7'(wy);
        bus.colour      = col;
        bus.query_valid = qv;
        bus.query_x     = 8'(qx);
        bus.query_y     = 7'(qy);
        if (we && wx < 160 && wy < 120) model[wy*160 + wx] = (col != 3'b000);
        if (qv) exp_q.push_back((qx >= 160 || qy >= 120) ? 1'b1 : model[qy*160 + qx]);
        tick();
        bus.writeEn     = 1'b0;
        bus.query_valid = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 16'(bus.hit_valid), 16'd1);
            check({tag, "_hit"}, 16'(bus.hit), 16'(e));
            $display("query %s: hit=%0d expected=%0d", tag, bus.hit, e);
        end else begin
            check({tag, "_noresp"}, 16'(bus.hit_valid), 16'd0);
            $display("cycle %s: no response", tag);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.writeEn     = 1'b0;
        bus.x           = '0;
        bus.y           = '0;
        bus.colour      = '0;
        bus.clear_req   = 1'b0;
        bus.query_valid = 1'b0;
        bus.query_x     = '0;
        bus.query_y     = '0;
        foreach (model[i]) model[i] = 1'b0;
`ifdef PIXEL_OOB_COUNT_EN
        oob_exp = 8'd2;
`else
        oob_exp = 8'd0;
`endif

        repeat (3) tick();
        check("rst_clearing", 16'(bus.clearing), 16'd1);
        check("rst_ready", 16'(bus.query_ready), 16'd0);
        check("rst_hit_valid", 16'(bus.hit_valid), 16'd0);
        check("rst_hit", 16'(bus.hit), 16'd0);
        check("rst_oob", 16'(bus.oob_count), 16'd0);

        reset = 1'b0;
        n = 0;
        while (bus.clearing === 1'b1 && n < 25000) begin
            n++;
            tick();
        end
        check("clear_len", 16'(n), 16'd19200);
        check("ready_after_clear", 16'(bus.query_ready), 16'd1);
        $display("initial sweep: %0d cycles", n);

        cycle("q00", 0, 0, 0, 3'b000, 1, 0, 0);

        cycle("w30_108", 1, 30, 108, 3'b111, 0, 0, 0);
        cycle("q30_108_set", 0, 0, 0, 3'b000, 1, 30, 108);
        cycle("w30_108_bg", 1, 30, 108, 3'b000, 0, 0, 0);
        cycle("q30_108_clr", 0, 0, 0, 3'b000, 1, 30, 108);

        cycle("fwd5_35", 1, 5, 35, 3'b101, 1, 5, 35);
        cycle("b2b5_35", 0, 0, 0, 3'b000, 1, 5, 35);
        cycle("b2b6_35", 0, 0, 0, 3'b000, 1, 6, 35);
        cycle("idle", 0, 0, 0, 3'b000, 0, 0, 0);

        cycle("oob_w160", 1, 160, 10, 3'b111, 0, 0, 0);
        cycle("oob_w120", 1, 10, 120, 3'b111, 0, 0, 0);
        check("oob_count", 16'(bus.oob_count), 16'(oob_exp));
        cycle("q0_11", 0, 0, 0, 3'b000, 1, 0, 11);
        cycle("q160_10", 0, 0, 0, 3'b000, 1, 160, 10);
        cycle("w159_119", 1, 159, 119, 3'b010, 0, 0, 0);
        cycle("q159_119", 0, 0, 0, 3'b000, 1, 159, 119);
        cycle("q200_0", 0, 0, 0, 3'b000, 1, 200, 0);
        cycle("hold", 0, 0, 0, 3'b000, 0, 0, 0);
        check("hit_hold", 16'(bus.hit), 16'd1);

        for (int i = 0; i < 160; i++) cycle("fill35", 1, i, 35, 3'b001, 0, 0, 0);
        cycle("q80_35_full", 0, 0, 0, 3'b000, 1, 80, 35);

        // clear_req with a query in the same cycle: that response still arrives.
        bus.clear_req = 1'b1;
        cycle("q7_35_at_clear", 0, 0, 0, 3'b000, 1, 7, 35);
        bus.clear_req = 1'b0;
        check("clr_clearing", 16'(bus.clearing), 16'd1);
        check("clr_ready", 16'(bus.query_ready), 16'd0);
        check("clr_oob", 16'(bus.oob_count), 16'd0);

        bus.query_valid = 1'b1;
        bus.query_x     = 8'd7;
        bus.query_y     = 7'd35;
        resp_seen       = 1'b0;
        repeat (100) begin
            tick();
            if (bus.hit_valid !== 1'b0) resp_seen = 1'b1;
        end
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        n = 0;
        while (bus.clearing === 1'b1 && n < 25000) begin
            n++;
            if (bus.hit_valid !== 1'b0) resp_seen = 1'b1;
            tick();
        end
        bus.query_valid = 1'b0;
        check("restart_len", 16'(n), 16'd19200);
        check("clear_no_resp", 16'(resp_seen), 16'd0);
        $display("restarted sweep: %0d cycles", n);
        foreach (model[i]) model[i] = 1'b0;

        cycle("after_clear", 0, 0, 0, 3'b000, 0, 0, 0);
        cycle("q80_35_cleared", 0, 0, 0, 3'b000, 1, 80, 35);
        cycle("q0_35_cleared", 0, 0, 0, 3'b000, 1, 0, 35);
        cycle("q159_35_cleared", 0, 0, 0, 3'b000, 1, 159, 35);

        // Reset lands in the cycle the response would be visible.
        bus.query_valid = 1'b1;
        bus.query_x     = 8'd5;
        bus.query_y     = 7'd35;
        @(posedge clk);
        #1;
        reset           = 1'b1;
        bus.query_valid = 1'b0;
        #1;
        check("rstq_hit_valid", 16'(bus.hit_valid), 16'd0);
        check("rstq_ready", 16'(bus.query_ready), 16'd0);
        check("rstq_clearing", 16'(bus.clearing), 16'd1);
        $display("reset mid-query: hit_valid=%0d query_ready=%0d", bus.hit_valid, bus.query_ready);
        exp_q.delete();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
